// File: rtl/line_column_sum24.sv
// line_column_sum24: vertical NUM_TAPS-row column accumulator placed behind the line buffer.
// Forwards the pixel stream into the line buffer, tags every pixel with frame coordinates,
// reduces the aligned taps through a pipelined adder tree, and emits sum, mean, tag and flags.
// Optional build macro: COLSUM_ZERO_FILL_EN zeroes taps that lie above row 0 of the current frame.
// The adder tree is 4-tap groups followed by two equal halves, so NUM_TAPS must be a multiple of 8.
module line_column_sum24 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_TAPS    = 24,
    parameter int unsigned LINE_WIDTH  = 800,
    parameter int unsigned FRAME_LINES = 600,
    localparam int unsigned SUM_W      = $clog2(NUM_TAPS * ((1 << WIDTH) - 1) + 1),
    localparam int unsigned XY_W       = 10
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [WIDTH-1:0]          in_pixel,
    output logic                      lb_clken,
    output logic [WIDTH-1:0]          lb_shiftin,
    input  logic [NUM_TAPS*WIDTH-1:0] lb_taps,
    output logic                      out_valid,
    output logic [SUM_W-1:0]          out_sum,
    output logic [WIDTH-1:0]          out_mean,
    output logic [XY_W-1:0]           out_x,
    output logic [XY_W-1:0]           out_y,
    output logic                      out_full,
    output logic                      out_frame_done
);

    localparam int unsigned PIX_MAX = (1 << WIDTH) - 1;
    localparam int unsigned G1_TAPS = 4;
    localparam int unsigned G1_N    = NUM_TAPS / G1_TAPS;
    localparam int unsigned G2_N    = 2;
    localparam int unsigned G2_IN   = G1_N / G2_N;
    localparam int unsigned P1_W    = $clog2(G1_TAPS * PIX_MAX + 1);
    localparam int unsigned P2_W    = $clog2(G1_TAPS * G2_IN * PIX_MAX + 1);

    localparam logic [XY_W-1:0] LAST_X = XY_W'(LINE_WIDTH - 1);
    localparam logic [XY_W-1:0] LAST_Y = XY_W'(FRAME_LINES - 1);
    localparam logic [XY_W-1:0] FULL_Y = XY_W'(NUM_TAPS);

    // coordinate counter and the tag of the pixel presented this cycle
    logic [XY_W-1:0] x_q, y_q;
    logic [XY_W-1:0] tag_x, tag_y, next_x, next_y;

    // S0: tag stage
    logic            s0_valid, s0_full, s0_last;
    logic [XY_W-1:0] s0_x, s0_y;

    // S1: six 4-tap partial sums
    logic [WIDTH-1:0] tap  [NUM_TAPS];
    logic [P1_W-1:0]  p1_d [G1_N];
    logic [P1_W-1:0]  s1_p [G1_N];
    logic             s1_valid, s1_full, s1_last;
    logic [XY_W-1:0]  s1_x, s1_y;

    // S2: two partial sums of three groups each
    logic [P2_W-1:0]  p2_d [G2_N];
    logic [P2_W-1:0]  s2_p [G2_N];
    logic             s2_valid, s2_full, s2_last;
    logic [XY_W-1:0]  s2_x, s2_y;

    // S3 final sum and mean, registered in the output stage
    logic [SUM_W-1:0] sum_d;
    logic [WIDTH-1:0] mean_d;

    // zero-latency pass-through into the line buffer
    assign lb_clken   = in_valid;
    assign lb_shiftin = in_pixel;

    // tag selection (sof restarts at the origin) and next counter position
    always_comb begin
        tag_x  = in_sof ? '0 : x_q;
        tag_y  = in_sof ? '0 : y_q;
        next_x = tag_x + XY_W'(1);
        next_y = tag_y;
        if (tag_x == LAST_X) begin
            next_x = '0;
            next_y = (tag_y == LAST_Y) ? '0 : tag_y + XY_W'(1);
        end
    end

    // coordinate counter, advances only on accepted pixels
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (in_valid) begin
            x_q <= next_x;
            y_q <= next_y;
        end
    end

    // S0 register: valid, tag and per-pixel flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
            s0_full  <= 1'b0;
            s0_last  <= 1'b0;
        end else begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_x    <= tag_x;
                s0_y    <= tag_y;
                s0_full <= (tag_y >= FULL_Y);
                s0_last <= (tag_x == LAST_X) && (tag_y == LAST_Y);
            end
        end
    end

    // unpack taps (optionally masking rows above the frame start) and form 4-tap sums
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            tap[k] = lb_taps[k*WIDTH +: WIDTH];
`ifdef COLSUM_ZERO_FILL_EN
            if (XY_W'(k) >= s0_y) tap[k] = '0;
`endif
        end
        for (int g = 0; g < G1_N; g++) begin
            p1_d[g] = '0;
            for (int i = 0; i < G1_TAPS; i++) begin
                p1_d[g] = p1_d[g] + P1_W'(tap[g*G1_TAPS + i]);
            end
        end
    end

    // S1 register: partial sums and forwarded tag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_full  <= 1'b0;
            s1_last  <= 1'b0;
            for (int g = 0; g < G1_N; g++) s1_p[g] <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_x    <= s0_x;
                s1_y    <= s0_y;
                s1_full <= s0_full;
                s1_last <= s0_last;
                for (int g = 0; g < G1_N; g++) s1_p[g] <= p1_d[g];
            end
        end
    end

    // second tree level: each half adds G2_IN first-level sums
    always_comb begin
        for (int h = 0; h < G2_N; h++) begin
            p2_d[h] = '0;
            for (int i = 0; i < G2_IN; i++) begin
                p2_d[h] = p2_d[h] + P2_W'(s1_p[h*G2_IN + i]);
            end
        end
    end

    // S2 register: half sums and forwarded tag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
            s2_full  <= 1'b0;
            s2_last  <= 1'b0;
            for (int h = 0; h < G2_N; h++) s2_p[h] <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x    <= s1_x;
                s2_y    <= s1_y;
                s2_full <= s1_full;
                s2_last <= s1_last;
                for (int h = 0; h < G2_N; h++) s2_p[h] <= p2_d[h];
            end
        end
    end

    // final sum and exact floor mean (constant divisor)
    always_comb begin
        sum_d  = SUM_W'(s2_p[0]) + SUM_W'(s2_p[1]);
        mean_d = WIDTH'(sum_d / SUM_W'(NUM_TAPS));
    end

    // output register: data holds while idle, frame-done is a qualified pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_sum        <= '0;
            out_mean       <= '0;
            out_x          <= '0;
            out_y          <= '0;
            out_full       <= 1'b0;
            out_frame_done <= 1'b0;
        end else begin
            out_valid      <= s2_valid;
            out_frame_done <= s2_valid & s2_last;
            if (s2_valid) begin
                out_sum  <= sum_d;
                out_mean <= mean_d;
                out_x    <= s2_x;
                out_y    <= s2_y;
                out_full <= s2_full;
            end
        end
    end

endmodule

// File: tb/tb_line_column_sum24.sv
// Bench for line_column_sum24: table of hand-derived probe points plus a stream-level
// reference model checking every output cycle. Frame geometry is shrunk (64x40) so whole
// frames, wraps and frame-done fit in a short run; tap count and pixel width are nominal.
module tb_line_column_sum24;

    localparam int LW = 64;
    localparam int FL = 40;
    localparam int NT = 24;
    localparam int W  = 8;
    localparam int LB_DEPTH = 65536;
    localparam logic [7:0] PU = 8'h5A;   // line-buffer contents before any pixel

`ifdef COLSUM_ZERO_FILL_EN
    localparam int A_SUM = 5865; localparam int A_MEAN = 244;
    localparam int E_SUM = 48;   localparam int E_MEAN = 2;
`else
    localparam int A_SUM = 5955; localparam int A_MEAN = 248;
    localparam int E_SUM = 5403; localparam int E_MEAN = 225;
`endif

    typedef struct {
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [12:0] sum;
        logic [7:0]  mean;
        logic        full;
        logic        done;
    } exp_t;

    typedef struct {
        logic       sof;
        logic       ramp;
        logic [7:0] pix;
        int         lines;
        int         px;
        int         py;
        int         sum;
        int         mean;
        logic       full;
        int         done;
    } vec_t;

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic               in_sof;
    logic [W-1:0]       in_pixel;
    logic               lb_clken;
    logic [W-1:0]       lb_shiftin;
    logic [NT*W-1:0]    lb_taps;
    logic               out_valid;
    logic [12:0]        out_sum;
    logic [W-1:0]       out_mean;
    logic [9:0]         out_x;
    logic [9:0]         out_y;
    logic               out_full;
    logic               out_frame_done;

    line_column_sum24 #(
        .WIDTH(W), .NUM_TAPS(NT), .LINE_WIDTH(LW), .FRAME_LINES(FL)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .lb_clken(lb_clken), .lb_shiftin(lb_shiftin), .lb_taps(lb_taps),
        .out_valid(out_valid), .out_sum(out_sum), .out_mean(out_mean),
        .out_x(out_x), .out_y(out_y), .out_full(out_full),
        .out_frame_done(out_frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // behavioural line buffer: tap k = pixel shifted in (k+1)*LW pixels before the newest
    logic [7:0] lb_mem [LB_DEPTH];
    int         lb_cnt = 0;

    always @(posedge clock) begin
        if (lb_clken && lb_cnt < LB_DEPTH) begin
            lb_mem[lb_cnt] <= lb_shiftin;
            lb_cnt         <= lb_cnt + 1;
        end
    end

    always_comb begin
        lb_taps = '0;
        for (int k = 0; k < NT; k++) begin
            if (lb_cnt - (k + 1) * LW - 1 < 0) lb_taps[k*W +: W] = PU;
            else                               lb_taps[k*W +: W] = lb_mem[lb_cnt - (k + 1) * LW - 1];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [7:0] ref_stream [LB_DEPTH];
    int         ref_n = 0;
    int         mx = 0;
    int         my = 0;
    exp_t       exp_q [$];

    // drive one cycle of input and queue the result the DUT owes four cycles later
    task automatic step(input logic v, input logic sof, input logic [7:0] pix);
        exp_t       e;
        int         s;
        int         j;
        logic [7:0] p;
        @(posedge clock);
        #1;
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        e = '{default: '0};
        e.valid = v;
        if (v) begin
            if (sof) begin
                mx = 0;
                my = 0;
            end
            ref_stream[ref_n] = pix;
            s = 0;
            for (int k = 0; k < NT; k++) begin
                j = ref_n - (k + 1) * LW;
                p = (j < 0) ? PU : ref_stream[j];
`ifdef COLSUM_ZERO_FILL_EN
                if (k >= my) p = 8'h00;
`endif
                s += int'(p);
            end
            e.x    = 10'(mx);
            e.y    = 10'(my);
            e.sum  = 13'(s);
            e.mean = 8'(s / NT);
            e.full = (my >= NT);
            e.done = (mx == LW - 1) && (my == FL - 1);
            ref_n++;
            mx++;
            if (mx == LW) begin
                mx = 0;
                my++;
                if (my == FL) my = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    // output monitor state
    int          probe_x = -1;
    int          probe_y = -1;
    logic        probe_hit = 1'b0;
    logic [21:0] cap = '0;
    int          done_cnt = 0;
    int          valid_seen = 0;
    logic        log_en = 1'b0;
    logic [19:0] tag_log [$];

    // monitor/scoreboard, sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (out_frame_done) done_cnt++;
                if (out_valid) valid_seen++;
                if (out_valid && log_en) tag_log.push_back({out_x, out_y});
                if (out_valid && !probe_hit && int'(out_x) == probe_x && int'(out_y) == probe_y) begin
                    probe_hit = 1'b1;
                    cap = {out_sum, out_mean, out_full};
                end
                if (exp_q.size() > 4) begin
                    e = exp_q.pop_front();
                    chk("valid_done", 64'({out_valid, out_frame_done}), 64'({e.valid, e.valid & e.done}));
                    if (e.valid)
                        chk("data", 64'({out_sum, out_mean, out_x, out_y, out_full}),
                                    64'({e.sum, e.mean, e.x, e.y, e.full}));
                end
            end
        end
    end

    vec_t vecs [5];

    initial begin
        int  done0;
        logic found;

        vecs[0] = '{sof: 1'b1, ramp: 1'b0, pix: 8'hFF, lines: 30, px: 0,  py: 23,
                    sum: A_SUM, mean: A_MEAN, full: 1'b0, done: 0};
        vecs[1] = '{sof: 1'b1, ramp: 1'b0, pix: 8'hFF, lines: 30, px: 10, py: 24,
                    sum: 6120,  mean: 255,    full: 1'b1, done: 0};
        vecs[2] = '{sof: 1'b1, ramp: 1'b1, pix: 8'h00, lines: FL, px: 5,  py: 30,
                    sum: 420,   mean: 17,     full: 1'b1, done: 1};
        vecs[3] = '{sof: 1'b1, ramp: 1'b0, pix: 8'hFF, lines: 30, px: 63, py: 29,
                    sum: 6120,  mean: 255,    full: 1'b1, done: 0};
        vecs[4] = '{sof: 1'b1, ramp: 1'b0, pix: 8'h10, lines: 4,  px: 0,  py: 3,
                    sum: E_SUM, mean: E_MEAN, full: 1'b0, done: 0};

        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_pixel = 8'h3C;
        #1;
        chk("reset_state", 64'({out_valid, out_sum, out_mean, out_x, out_y, out_full, out_frame_done}), 64'(0));
        chk("lb_passthru", 64'({lb_clken, lb_shiftin}), 64'({1'b1, 8'h3C}));
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // table of probe points, each streamed at full rate
        for (int t = 0; t < 5; t++) begin
            probe_x   = vecs[t].px;
            probe_y   = vecs[t].py;
            probe_hit = 1'b0;
            done0     = done_cnt;
            for (int l = 0; l < vecs[t].lines; l++)
                for (int x = 0; x < LW; x++)
                    step(1'b1, vecs[t].sof && l == 0 && x == 0, vecs[t].ramp ? 8'(l) : vecs[t].pix);
            repeat (6) step(1'b0, 1'b0, 8'h00);
            chk($sformatf("probe%0d_seen", t), 64'(probe_hit), 64'(1));
            if (probe_hit)
                chk($sformatf("probe%0d_data", t), 64'(cap),
                    64'({13'(vecs[t].sum), 8'(vecs[t].mean), vecs[t].full}));
            chk($sformatf("probe%0d_frame_done", t), 64'(done_cnt - done0), 64'(vecs[t].done));
        end
        probe_x = -1;
        probe_y = -1;

        // valid gap pattern 1,0,1,1,0
        step(1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        repeat (6) step(1'b0, 1'b0, 8'h00);

        // random traffic with gaps and occasional mid-frame sof
        for (int i = 0; i < 3000; i++) begin
            logic v;
            v = ($urandom_range(0, 3) != 0);
            step(v, v && ($urandom_range(0, 299) == 0), 8'($urandom));
        end
        repeat (6) step(1'b0, 1'b0, 8'h00);

        // sof arriving right after tag (40,10)
        tag_log.delete();
        log_en = 1'b1;
        step(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < LW * FL && !(mx == 41 && my == 10); i++)
            step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'($urandom));
        repeat (3) step(1'b1, 1'b0, 8'($urandom));
        repeat (6) step(1'b0, 1'b0, 8'h00);
        log_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i + 2 < tag_log.size(); i++) begin
            if (!found && tag_log[i] == {10'd40, 10'd10}) begin
                found = 1'b1;
                chk("sof_retag", 64'({tag_log[i+1], tag_log[i+2]}), 64'({10'd0, 10'd0, 10'd1, 10'd0}));
            end
        end
        chk("sof_tag_seen", 64'(found), 64'(1));

        // asynchronous reset in the middle of streaming
        repeat (100) step(1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'h00);
        chk("busy_before_reset", 64'(out_valid), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("reset_async", 64'({out_valid, out_sum, out_mean, out_x, out_y, out_full, out_frame_done}), 64'(0));
        exp_q.delete();
        mx = 0;
        my = 0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        valid_seen = 0;
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("no_valid_after_reset", 64'(valid_seen), 64'(0));
        step(1'b1, 1'b0, 8'h77);
        repeat (6) step(1'b0, 1'b0, 8'h00);
        chk("one_valid_after_restart", 64'(valid_seen), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
